jt7759_romrd: RTL and testbench

JT7759_ROMRD -- requirements
Module: jt7759_romrd

---
 rtl/jt7759_romrd.sv | 273 +++++++++++++++++++++++++++
 tb/tb_jt7759_romrd.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_romrd.sv
// -----------------------------------------------------------------------------
// jt7759_romrd
//
// Byte-read front end between the uPD7759 ADPCM core and a 16-bit sample-ROM
// port. Two word buffers (W0, W1) hold recently fetched ROM words. Pointer P
// names the primary buffer. The other buffer is the landing slot for demand
// misses and for the optional next-word prefetch. When the sound core walks
// forward into the non-primary buffer, the two roles swap. The old primary
// buffer is then refilled with the following word.
//
// Parameters
//   PREFETCH   1: fetch word tag+1 after each demand fetch or swap; 0: never
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   rom_cs     byte-read request from the sound core
//   rom_addr   17-bit byte address of the requested byte
//   rom_data   returned byte (registered, held between hits)
//   rom_ok     rom_data is valid for the current rom_addr (registered)
//   flush      one-cycle pulse invalidating both buffers (ROM reload)
//   mem_req    memory read request, held until acknowledged
//   mem_addr   memory word address (byte address bits [16:1])
//   mem_data   memory read word, little-endian byte order
//   mem_ack    one-cycle strobe qualifying mem_data
// -----------------------------------------------------------------------------
module jt7759_romrd #(
    parameter int PREFETCH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_cs,
    input  logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_ok,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_ack
);

    localparam logic PF_EN = (PREFETCH != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PREF  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Buffer storage: tags and data carry no reset, only the valid bits do.
    logic [1:0]  r_valid;
    logic [15:0] r_tag  [2];
    logic [15:0] r_data [2];
    logic        r_p;          // primary buffer index
    logic        r_tgt;        // buffer written by the in-flight transaction
    logic        r_discard;    // flush seen during the in-flight transaction

    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic        r_rom_ok;
    logic [7:0]  r_rom_data;
    logic [16:0] r_prev_addr;
    logic        r_prev_cs;

    // Lookup
    logic [15:0] w_word;
    logic [15:0] w_word_inc;
    logic [15:0] w_mem_inc;
    logic        w_hit0;
    logic        w_hit1;
    logic        w_hit;
    logic        w_hit_idx;
    logic [15:0] w_hit_word;
    logic [7:0]  w_byte;
    logic        w_stable;
    logic        w_ack;
    logic        w_discard_now;
    logic        w_tgt_n;
    logic        w_idle_pf_held;
    logic        w_fetch_pf_held;

    // FSM decisions applied by the register process
    logic        w_req_set;
    logic        w_req_clr;
    logic [15:0] w_addr_nxt;
    logic        w_tgt_nxt;
    logic        w_p_nxt;
    logic        w_load;
    logic        w_discard_nxt;

    assign w_word     = rom_addr[16:1];
    assign w_word_inc = w_word + 16'd1;       // wraps FFFF -> 0000
    assign w_mem_inc  = r_mem_addr + 16'd1;   // wraps FFFF -> 0000

    assign w_hit0     = rom_cs & r_valid[0] & (r_tag[0] == w_word);
    assign w_hit1     = rom_cs & r_valid[1] & (r_tag[1] == w_word);
    assign w_hit      = w_hit0 | w_hit1;
    // Only meaningful when w_hit is set; the two tags are never equal.
    assign w_hit_idx  = ~w_hit0;
    assign w_hit_word = w_hit_idx ? r_data[1] : r_data[0];
    assign w_byte     = rom_addr[0] ? w_hit_word[15:8] : w_hit_word[7:0];

    // rom_ok needs the same request on two consecutive cycles, so a changed
    // address never sees a result that was looked up for the previous one.
    assign w_stable   = (rom_addr == r_prev_addr) & (rom_cs == r_prev_cs);

    // A strobe without an outstanding request (e.g. left over from before a
    // reset) is ignored.
    assign w_ack      = mem_ack & r_mem_req;

    // Flush on the ack cycle itself wins over the returning data.
    assign w_discard_now = flush | r_discard;

    assign w_tgt_n    = ~r_tgt;

    // On a swap the old primary (r_p) becomes the prefetch slot; skip the
    // prefetch if it already holds the following word.
    assign w_idle_pf_held  = r_valid[r_p] & (r_tag[r_p] == w_word_inc);
    // After a demand fetch the other buffer is the prefetch slot.
    assign w_fetch_pf_held = r_valid[w_tgt_n] & (r_tag[w_tgt_n] == w_mem_inc);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_req_set     = 1'b0;
        w_req_clr     = 1'b0;
        w_addr_nxt    = r_mem_addr;
        w_tgt_nxt     = r_tgt;
        w_p_nxt       = r_p;
        w_load        = 1'b0;
        w_discard_nxt = r_discard;

        case (r_state)
            IDLE: begin
                // The flush cycle itself only clears the valid bits; the
                // request is looked up again on the next cycle.
                if (!flush) begin
                    if (rom_cs && !w_hit) begin
                        w_state_nxt = FETCH;
                        w_req_set   = 1'b1;
                        w_addr_nxt  = w_word;
                        w_tgt_nxt   = ~r_p;
                    end else if (w_hit && (w_hit_idx != r_p)) begin
                        w_p_nxt = ~r_p;
                        if (PF_EN && !w_idle_pf_held) begin
                            w_state_nxt = PREF;
                            w_addr_nxt  = w_word_inc;
                            w_tgt_nxt   = r_p;
                        end
                    end
                end
            end

            FETCH: begin
                if (w_ack) begin
                    w_req_clr = 1'b1;
                    if (w_discard_now) begin
                        w_state_nxt   = IDLE;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_load  = 1'b1;
                        w_p_nxt = r_tgt;
                        if (PF_EN && !w_fetch_pf_held) begin
                            w_state_nxt = PREF;
                            w_addr_nxt  = w_mem_inc;
                            w_tgt_nxt   = ~r_tgt;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end else if (flush) begin
                    w_discard_nxt = 1'b1;
                end
            end

            PREF: begin
                // PREF is entered with mem_req low so that every ack is
                // followed by one idle request cycle; raise it here.
                if (w_ack) begin
                    w_req_clr     = 1'b1;
                    w_state_nxt   = IDLE;
                    w_discard_nxt = 1'b0;
                    w_load        = ~w_discard_now;
                end else begin
                    if (!r_mem_req) begin
                        w_req_set = 1'b1;
                    end
                    if (flush) begin
                        w_discard_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers and outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_valid     <= 2'b00;
            r_p         <= 1'b0;
            r_tgt       <= 1'b0;
            r_discard   <= 1'b0;
            r_rom_ok    <= 1'b0;
            r_rom_data  <= 8'd0;
            r_prev_addr <= 17'd0;
            r_prev_cs   <= 1'b0;
        end else begin
            if (w_req_set) begin
                r_mem_req <= 1'b1;
            end else if (w_req_clr) begin
                r_mem_req <= 1'b0;
            end
            r_mem_addr <= w_addr_nxt;
            r_tgt      <= w_tgt_nxt;
            r_p        <= w_p_nxt;
            r_discard  <= w_discard_nxt;

            if (flush) begin
                r_valid <= 2'b00;
            end else if (w_load) begin
                r_valid[r_tgt] <= 1'b1;
            end

            r_rom_ok <= w_hit & w_stable & ~flush;
            if (w_hit) begin
                r_rom_data <= w_byte;
            end
            r_prev_addr <= rom_addr;
            r_prev_cs   <= rom_cs;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer tag/data storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_tag[r_tgt]  <= r_mem_addr;
            r_data[r_tgt] <= mem_data;
        end
    end

    assign rom_data = r_rom_data;
    assign rom_ok   = r_rom_ok;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_jt7759_romrd.sv
// -----------------------------------------------------------------------------
// tb_jt7759_romrd
//
// Bench for jt7759_romrd. One instance runs with prefetch on and one with
// prefetch off. A per-cycle vector table covers the cold miss, prefetch and
// buffer swaps. Short hand-written sequences cover wrap, address change
// during a fetch, flush, reset and the no-prefetch build.
// -----------------------------------------------------------------------------
module tb_jt7759_romrd;

    logic        clk = 1'b0;
    logic        rst;

    logic        rom_cs;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack;

    logic        n_cs;
    logic [16:0] n_addr;
    logic [7:0]  n_data;
    logic        n_ok;
    logic        n_flush;
    logic        n_req;
    logic [15:0] n_maddr;
    logic [15:0] n_md;
    logic        n_ack;

    int          n_cmp  = 0;
    int          n_fail = 0;

    logic        watch_en   = 1'b0;
    logic [7:0]  watch_byte = 8'h00;
    int          watch_bad  = 0;

    typedef struct {
        logic        cs;
        logic [16:0] addr;
        logic        ack;
        logic [15:0] md;
        logic        ok;
        logic [7:0]  rd;
        logic        req;
        logic [15:0] ma;
    } vec_t;

    vec_t tbl [27];

    always #5 clk = ~clk;

    jt7759_romrd #(.PREFETCH(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ack  (mem_ack)
    );

    jt7759_romrd #(.PREFETCH(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .rom_cs   (n_cs),
        .rom_addr (n_addr),
        .rom_data (n_data),
        .rom_ok   (n_ok),
        .flush    (n_flush),
        .mem_req  (n_req),
        .mem_addr (n_maddr),
        .mem_data (n_md),
        .mem_ack  (n_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (watch_en && rom_ok && (rom_data != watch_byte)) watch_bad++;
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait (bounded) for a request on the prefetch-enabled instance, check its
    // address, hold for dly cycles and then return one ack with data.
    task automatic serve(input logic [15:0] exp_addr, input logic [15:0] data,
                         input int dly, input string nm);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chkb({nm, "_req"}, mem_req, 1'b1);
        chk16({nm, "_addr"}, mem_addr, exp_addr);
        if (mem_req) begin
            for (int k = 0; k < dly; k++) begin
                step();
                chkb({nm, "_hold_req"}, mem_req, 1'b1);
                chk16({nm, "_hold_addr"}, mem_addr, exp_addr);
            end
            mem_data = data;
            mem_ack  = 1'b1;
            step();
            mem_ack  = 1'b0;
            chkb({nm, "_req_drop"}, mem_req, 1'b0);
        end
    endtask

    initial begin
        logic [7:0]  p0_exp [4];
        logic [15:0] fetched [4];
        int          nf;
        logic        got;

        //            cs    addr       ack   md       ok    rd     req   ma
        tbl[0]  = '{1'b1, 17'h00123, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0091};
        tbl[1]  = '{1'b1, 17'h00123, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0091};
        tbl[2]  = '{1'b1, 17'h00123, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0091};
        tbl[3]  = '{1'b1, 17'h00123, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0091};
        tbl[4]  = '{1'b1, 17'h00123, 1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 16'h0092};
        tbl[5]  = '{1'b1, 17'h00123, 1'b0, 16'h0000, 1'b1, 8'hBE, 1'b1, 16'h0092};
        tbl[6]  = '{1'b1, 17'h00123, 1'b0, 16'h0000, 1'b1, 8'hBE, 1'b1, 16'h0092};
        tbl[7]  = '{1'b1, 17'h00123, 1'b1, 16'h1234, 1'b1, 8'hBE, 1'b0, 16'h0092};
        tbl[8]  = '{1'b1, 17'h00124, 1'b0, 16'h0000, 1'b0, 8'h34, 1'b0, 16'h0093};
        tbl[9]  = '{1'b1, 17'h00124, 1'b0, 16'h0000, 1'b1, 8'h34, 1'b1, 16'h0093};
        tbl[10] = '{1'b1, 17'h00124, 1'b1, 16'h5678, 1'b1, 8'h34, 1'b0, 16'h0093};
        tbl[11] = '{1'b1, 17'h00125, 1'b0, 16'h0000, 1'b0, 8'h12, 1'b0, 16'h0093};
        tbl[12] = '{1'b1, 17'h00125, 1'b0, 16'h0000, 1'b1, 8'h12, 1'b0, 16'h0093};
        tbl[13] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b0, 8'h78, 1'b0, 16'h0094};
        tbl[14] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b1, 8'h78, 1'b1, 16'h0094};
        tbl[15] = '{1'b0, 17'h00126, 1'b1, 16'h9ABC, 1'b0, 8'h78, 1'b0, 16'h0094};
        tbl[16] = '{1'b0, 17'h00126, 1'b0, 16'h0000, 1'b0, 8'h78, 1'b0, 16'h0094};
        tbl[17] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b0, 8'h78, 1'b0, 16'h0094};
        tbl[18] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b1, 8'h78, 1'b0, 16'h0094};
        tbl[19] = '{1'b1, 17'h00126, 1'b1, 16'hFFFF, 1'b1, 8'h78, 1'b0, 16'h0094};
        tbl[20] = '{1'b1, 17'h00128, 1'b0, 16'h0000, 1'b0, 8'hBC, 1'b0, 16'h0095};
        tbl[21] = '{1'b1, 17'h00128, 1'b0, 16'h0000, 1'b1, 8'hBC, 1'b1, 16'h0095};
        tbl[22] = '{1'b1, 17'h00128, 1'b1, 16'h1111, 1'b1, 8'hBC, 1'b0, 16'h0095};
        tbl[23] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b0, 8'hBC, 1'b1, 16'h0093};
        tbl[24] = '{1'b1, 17'h00126, 1'b1, 16'h4321, 1'b0, 8'hBC, 1'b0, 16'h0093};
        tbl[25] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b1, 8'h21, 1'b0, 16'h0093};
        tbl[26] = '{1'b1, 17'h00126, 1'b0, 16'h0000, 1'b1, 8'h21, 1'b0, 16'h0093};

        p0_exp[0] = 8'h11;
        p0_exp[1] = 8'h22;
        p0_exp[2] = 8'h33;
        p0_exp[3] = 8'h44;

        rst      = 1'b1;
        rom_cs   = 1'b0;
        rom_addr = 17'd0;
        flush    = 1'b0;
        mem_data = 16'd0;
        mem_ack  = 1'b0;
        n_cs     = 1'b0;
        n_addr   = 17'd0;
        n_flush  = 1'b0;
        n_md     = 16'd0;
        n_ack    = 1'b0;

        // Reset state
        step();
        step();
        chkb("rst_ok", rom_ok, 1'b0);
        chk8("rst_data", rom_data, 8'h00);
        chkb("rst_req", mem_req, 1'b0);
        chk16("rst_addr", mem_addr, 16'h0000);
        chkb("rst0_req", n_req, 1'b0);
        chkb("rst0_ok", n_ok, 1'b0);
        rst = 1'b0;

        // Cold miss, prefetch, swaps, skipped prefetch
        for (int i = 0; i < 27; i++) begin
            rom_cs   = tbl[i].cs;
            rom_addr = tbl[i].addr;
            mem_ack  = tbl[i].ack;
            mem_data = tbl[i].md;
            step();
            mem_ack  = 1'b0;
            chkb($sformatf("v%0d_ok", i), rom_ok, tbl[i].ok);
            chk8($sformatf("v%0d_data", i), rom_data, tbl[i].rd);
            chkb($sformatf("v%0d_req", i), mem_req, tbl[i].req);
            chk16($sformatf("v%0d_maddr", i), mem_addr, tbl[i].ma);
        end

        // Wrap: word FFFF prefetches word 0000
        rom_addr = 17'h1FFFF;
        serve(16'hFFFF, 16'hAA55, 2, "wrap_fetch");
        chkb("wrap_ok_early", rom_ok, 1'b0);
        chk16("wrap_pf_addr", mem_addr, 16'h0000);
        step();
        chkb("wrap_ok", rom_ok, 1'b1);
        chk8("wrap_data", rom_data, 8'hAA);
        serve(16'h0000, 16'h0F0F, 1, "wrap_pref");

        // Address change while a fetch is in flight
        rom_addr = 17'h00200;
        step();
        chkb("chg_req", mem_req, 1'b1);
        chk16("chg_addr", mem_addr, 16'h0100);
        rom_addr   = 17'h00400;
        watch_byte = 8'hA5;
        watch_en   = 1'b1;
        step();
        chk16("chg_hold", mem_addr, 16'h0100);
        mem_data = 16'h7777;
        mem_ack  = 1'b1;
        step();
        mem_ack  = 1'b0;
        serve(16'h0101, 16'h6666, 1, "chg_pref");
        serve(16'h0200, 16'hC3A5, 1, "chg_refetch");
        step();
        chkb("chg_ok", rom_ok, 1'b1);
        chk8("chg_data", rom_data, 8'hA5);
        serve(16'h0201, 16'h5A5A, 0, "chg_pref2");
        watch_en = 1'b0;
        chki("chg_stale_ok", watch_bad, 0);

        // Flush coincident with ack: no buffer becomes valid, refetch follows
        rom_addr = 17'h00800;
        step();
        chkb("fa_req", mem_req, 1'b1);
        chk16("fa_addr", mem_addr, 16'h0400);
        mem_data = 16'hDEAD;
        mem_ack  = 1'b1;
        flush    = 1'b1;
        step();
        mem_ack  = 1'b0;
        flush    = 1'b0;
        chkb("fa_req_drop", mem_req, 1'b0);
        chkb("fa_ok0", rom_ok, 1'b0);
        step();
        chkb("fa_ok1", rom_ok, 1'b0);
        chkb("fa_refetch", mem_req, 1'b1);
        chk16("fa_refetch_addr", mem_addr, 16'h0400);
        serve(16'h0400, 16'hBEAD, 0, "fa_fetch");
        step();
        chkb("fa_hit_ok", rom_ok, 1'b1);
        chk8("fa_hit_data", rom_data, 8'hAD);
        serve(16'h0401, 16'h1357, 0, "fa_pref");

        // Flush while idle on a hit, then flush in the middle of the refetch
        step();
        chkb("fl_pre_ok", rom_ok, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chkb("fl_ok", rom_ok, 1'b0);
        chkb("fl_noreq", mem_req, 1'b0);
        step();
        chkb("fl_miss_req", mem_req, 1'b1);
        chk16("fl_miss_addr", mem_addr, 16'h0400);
        flush = 1'b1;
        step();
        flush = 1'b0;
        mem_data = 16'hEEEE;
        mem_ack  = 1'b1;
        step();
        mem_ack  = 1'b0;
        chkb("fm_req_drop", mem_req, 1'b0);
        step();
        chkb("fm_ok", rom_ok, 1'b0);
        chkb("fm_refetch", mem_req, 1'b1);
        chk16("fm_refetch_addr", mem_addr, 16'h0400);
        serve(16'h0400, 16'hBEAD, 0, "fm_fetch");
        step();
        chkb("fm_hit_ok", rom_ok, 1'b1);
        chk8("fm_hit_data", rom_data, 8'hAD);
        serve(16'h0401, 16'h1357, 0, "fm_pref");

        // Reset during a fetch, then a stale ack
        rom_addr = 17'h02000;
        step();
        chkb("rf_req", mem_req, 1'b1);
        chk16("rf_addr", mem_addr, 16'h1000);
        rst    = 1'b1;
        rom_cs = 1'b0;
        step();
        rst = 1'b0;
        chkb("rf_req_drop", mem_req, 1'b0);
        chkb("rf_ok", rom_ok, 1'b0);
        chk8("rf_data", rom_data, 8'h00);
        chk16("rf_maddr", mem_addr, 16'h0000);
        step();
        mem_data = 16'hFFFF;
        mem_ack  = 1'b1;
        step();
        mem_ack  = 1'b0;
        step();
        chkb("rf_stale_req", mem_req, 1'b0);
        chkb("rf_stale_ok", rom_ok, 1'b0);
        chk16("rf_stale_maddr", mem_addr, 16'h0000);
        chk8("rf_stale_data", rom_data, 8'h00);
        rom_cs = 1'b1;
        serve(16'h1000, 16'h00C6, 1, "rf_fetch");
        step();
        chkb("rf_hit_ok", rom_ok, 1'b1);
        chk8("rf_hit_data", rom_data, 8'hC6);
        serve(16'h1001, 16'h2468, 0, "rf_pref");

        // PREFETCH=0: four sequential bytes need exactly two demand fetches
        nf = 0;
        for (int a = 0; a < 4; a++) begin
            n_cs   = 1'b1;
            n_addr = 17'h00010 + 17'(a);
            got    = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                if (n_req) begin
                    if (nf < 4) fetched[nf] = n_maddr;
                    nf++;
                    n_md  = (n_maddr == 16'h0008) ? 16'h2211 : 16'h4433;
                    n_ack = 1'b1;
                end
                step();
                n_ack = 1'b0;
                if (n_ok) got = 1'b1;
            end
            chkb($sformatf("np_ok%0d", a), got, 1'b1);
            chk8($sformatf("np_data%0d", a), n_data, p0_exp[a]);
        end
        for (int k = 0; k < 4; k++) step();
        chkb("np_no_pref", n_req, 1'b0);
        chki("np_fetches", nf, 2);
        if (nf >= 2) begin
            chk16("np_fetch0", fetched[0], 16'h0008);
            chk16("np_fetch1", fetched[1], 16'h0009);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
